fmax_reduce: RTL
================

FMAX_REDUCE -- requirements
Module: fmax_reduce

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier carried for consistency with other floating-point operators.
REQ-002 SHALL have parameter N, default 4, window length in elements; legal range 1..256.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_data  input  9  operand in FloPoCo format {exc[8:7], sign[6], exp[5:3], frac[2:0]}.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  9  window maximum.
REQ-009 SHALL have port out_idx  output  IW  position of the maximum within the window; IW = max(1, clog2(N)).
REQ-010 SHALL have port out_valid  output  1  out_data/out_idx valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-012 SHALL accept an element when in_valid && in_ready at a clock edge.
REQ-013 SHALL implement states IDLE (no element held), ACCUM (1..N-1 elements held) and HOLD (result presented).
REQ-014 In IDLE, an accepted element SHALL load best and set best_idx=0 unconditionally; next state ACCUM, or HOLD if N==1.
REQ-015 In ACCUM, an accepted element SHALL replace best, with best_idx set to the element count, iff compare(X=best, Y=in_data).XltY==1.
REQ-016 Ties and incomparable zeros (+0 vs -0) SHALL keep the earlier element.
REQ-017 A counter SHALL track accepted elements, 0..N-1; acceptance of element N-1 SHALL move to HOLD and clear the counter.
REQ-018 out_valid SHALL assert exactly one cycle after the edge accepting the N-th element (latency 1).
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; no input is consumed in HOLD.
REQ-020 In HOLD, out_data, out_idx and out_valid SHALL stay stable until out_valid && out_ready, then go to IDLE; throughput is N elements per N+1 cycles with no backpressure.
REQ-021 out_data and out_idx SHALL be driven from registers, with no combinational path from in_data.

Reset
REQ-022 rst SHALL force state IDLE, counter 0, best 9'h000, best_idx 0, out_valid 0, out_data 9'h000, out_idx 0; in_ready SHALL be 1 in the cycle after reset.
REQ-023 rst asserted mid-window SHALL discard the partial window; the next accepted element is index 0 of a new window.
REQ-024 rst SHALL take priority over a simultaneous accept or out_ready.

Configuration
REQ-025 Macro FMAX_NAN_PROPAGATE_EN SHALL select the NaN policy.
REQ-026 With FMAX_NAN_PROPAGATE_EN defined: the first NaN (exc=11) in a window SHALL be latched with its index, and all later elements in that window SHALL be ignored; the result is that NaN.
REQ-027 Without FMAX_NAN_PROPAGATE_EN: an incoming NaN SHALL never replace best; a held NaN SHALL be replaced by the next non-NaN element; an all-NaN window SHALL return the first NaN with index 0.

Structure
REQ-028 Package fmax_pkg SHALL hold WE=3, WF=3, W=WE+WF+3, the exception encodings (ZERO=00, NORMAL=01, INF=10, NAN=11) and the state enum.
REQ-029 The block SHALL instantiate exactly one existing comparator sub-module fcmplt, combinational, with X=best and Y=in_data; its unordered output SHALL drive the NaN logic.

Verification
REQ-030 N=4, inputs 0x098,0x0A0,0x0D8,0x000 back-to-back -> out_data=0x0A0, out_idx=1, out_valid one cycle after the 4th accept.
REQ-031 N=4, inputs 0x098 x4 -> out_idx=0; inputs 0x140(-inf),0x0D8,0x140,0x0D8 -> out_data=0x0D8, out_idx=1.
REQ-032 N=4, inputs 0x098,0x180,0x0A0,0x000 -> with the macro: 0x180, idx 1; without the macro: 0x0A0, idx 2.
REQ-033 out_ready held 0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, nothing consumed; out_ready=1 -> IDLE next cycle, next window starts at index 0.
REQ-034 rst pulsed after 2 accepts -> all outputs at reset values; the next 4 inputs 0x000,0x0A0,0x098,0x000 give 0x0A0, idx 1.
REQ-035 N=1, input 0x100 -> out_data=0x100, out_idx=0 one cycle later.

Source files
------------

// File: rtl/fmax_pkg.sv
// Shared definitions for the floating-point window-maximum block: FloPoCo operand
// layout {exc[W-1:W-2], sign, exp[WE], frac[WF]}, exception codes and FSM states.
package fmax_pkg;

    localparam int WE = 3;
    localparam int WF = 3;
    localparam int W  = WE + WF + 3;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    function automatic logic is_nan(input logic [W-1:0] v);
        return v[W-1:W-2] == EXC_NAN;
    endfunction

endpackage

// File: rtl/fcmplt.sv
// Combinational FloPoCo less-than comparator: xlty = (x < y) for ordered operands,
// unordered = either operand is NaN. +0 and -0 compare equal.
module fcmplt
    import fmax_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         xlty,
    output logic         unordered
);

    // Magnitude key ordered as zero < normal < inf; payload bits of zero/inf are ignored.
    function automatic logic [W-2:0] mag_key(input logic [W-1:0] v);
        logic [W-2:0] k;
        case (v[W-1:W-2])
            EXC_ZERO: k = '0;
            EXC_INF:  k = {EXC_INF, {(W-3){1'b0}}};
            default:  k = {v[W-1:W-2], v[W-4:0]};
        endcase
        return k;
    endfunction

    logic [W-2:0] kx;
    logic [W-2:0] ky;
    logic         sx;
    logic         sy;
    logic         both_zero;

    assign kx        = mag_key(x);
    assign ky        = mag_key(y);
    assign sx        = x[W-3];
    assign sy        = y[W-3];
    assign both_zero = (kx == '0) && (ky == '0);
    assign unordered = is_nan(x) || is_nan(y);

    always_comb begin
        xlty = 1'b0;
        if (!unordered) begin
            if (sx != sy)
                xlty = sx && !both_zero;
            else if (sx)
                xlty = kx > ky;
            else
                xlty = kx < ky;
        end
    end

endmodule

// File: rtl/fmax_reduce.sv
// Window maximum over N FloPoCo operands with index of the winner.
// NaN policy selected by macro FMAX_NAN_PROPAGATE_EN (defined: first NaN wins; default: NaNs skipped).
module fmax_reduce
    import fmax_pkg::*;
#(
    parameter int ID = 1,
    parameter int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_valid,
    input  logic          out_ready
);

    if (N < 1 || N > 256 || ID < 0) begin : g_bad_cfg
        $error("fmax_reduce: N must be 1..256 and ID non-negative");
    end

    state_t        state;
    logic [IW-1:0] cnt;
    logic [W-1:0]  best;
    logic [IW-1:0] best_idx;

    logic          accept;
    logic          first;
    logic          last;
    logic          cmp_lt;
    logic          cmp_unord;
    logic          best_nan;
    logic          in_nan;
    logic          take;
    logic [W-1:0]  nxt_best;
    logic [IW-1:0] nxt_idx;

    fcmplt u_cmp (
        .x         (best),
        .y         (in_data),
        .xlty      (cmp_lt),
        .unordered (cmp_unord)
    );

    assign in_ready = (state != ST_HOLD);
    assign accept   = in_valid && in_ready;
    assign first    = (state == ST_IDLE);
    assign last     = (cnt == IW'(N - 1));
    assign best_nan = is_nan(best);
    assign in_nan   = is_nan(in_data);

`ifdef FMAX_NAN_PROPAGATE_EN
    // A held NaN is sticky; an incoming NaN always displaces a non-NaN best.
    assign take = cmp_unord ? (!best_nan && in_nan) : cmp_lt;
`else
    // NaNs never win; a held NaN only survives until a real number shows up.
    assign take = cmp_unord ? (best_nan && !in_nan) : cmp_lt;
`endif

    always_comb begin
        nxt_best = best;
        nxt_idx  = best_idx;
        if (first) begin
            nxt_best = in_data;
            nxt_idx  = '0;
        end else if (take) begin
            nxt_best = in_data;
            nxt_idx  = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        best     <= nxt_best;
                        best_idx <= nxt_idx;
                        if (last) begin
                            // Result is registered on the accepting edge, visible next cycle.
                            state     <= ST_HOLD;
                            cnt       <= '0;
                            out_valid <= 1'b1;
                            out_data  <= nxt_best;
                            out_idx   <= nxt_idx;
                        end else begin
                            state <= ST_ACCUM;
                            cnt   <= cnt + IW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
